// File: rtl/core_out_uart_tx.sv
// core_out_uart_tx: buffers the core's character-output strobes in a FIFO and
// serialises them as 8N1 UART (LSB first) on tx.
//   clock          in  system clock, rising edge
//   reset_n        in  asynchronous active-low reset
//   out_en         in  one-cycle write strobe from the core
//   out_data       in  byte to send, valid while out_en=1
//   overflow_clear in  synchronous clear of the sticky overflow flag
//   tx             out UART line, idle high
//   busy           out frame in flight or FIFO non-empty
//   fifo_count     out bytes queued, excluding the one in the shifter
//   overflow       out sticky: a byte was dropped on a full FIFO
module core_out_uart_tx #(
    parameter int CLKS_PER_BIT    = 16,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     out_en,
    input  logic [7:0]               out_data,
    input  logic                     overflow_clear,
    output logic                     tx,
    output logic                     busy,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                     state, next_state;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count_nx;
    logic [BW-1:0]              baud;
    logic [2:0]                 bit_idx, bit_idx_nx;
    logic [7:0]                 shifter;
    logic                       pop, push, baud_done, tx_nx, busy_nx;

    assign pop       = (state == IDLE) && (fifo_count != '0);
    // count only reaches its top bit when the FIFO holds exactly DEPTH bytes
    assign push      = out_en && (!fifo_count[FIFO_DEPTH_LOG2] || pop);
    assign baud_done = baud == '0;
    assign count_nx  = fifo_count + (FIFO_DEPTH_LOG2+1)'(push) - (FIFO_DEPTH_LOG2+1)'(pop);

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= out_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            baud       <= BAUD_LAST;
            bit_idx    <= '0;
            shifter    <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= next_state;
            fifo_count <= count_nx;
            bit_idx    <= bit_idx_nx;
            tx         <= tx_nx;
            busy       <= busy_nx;
            // IDLE keeps the counter preloaded so a pop starts a full start bit
            baud       <= (state == IDLE || baud_done) ? BAUD_LAST : baud - 1'b1;
            overflow   <= (out_en && !push) ? 1'b1 : overflow_clear ? 1'b0 : overflow;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                shifter <= mem[rd_ptr];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = pop ? START : IDLE;
            START:   next_state = baud_done ? DATA : START;
            DATA:    next_state = (baud_done && bit_idx == 3'd7) ? STOP : DATA;
            default: next_state = baud_done ? IDLE : STOP;
        endcase
    end

    // outputs are computed from the next state so the registered tx/busy line up with it
    always_comb begin
        bit_idx_nx = (state == START) ? 3'd0 : (state == DATA && baud_done) ? bit_idx + 3'd1 : bit_idx;
        tx_nx      = (next_state == START) ? 1'b0 : (next_state == DATA) ? shifter[bit_idx_nx] : 1'b1;
        busy_nx    = (next_state != IDLE) || (count_nx != '0);
    end
endmodule

// File: tb/tb_core_out_uart_tx.sv
// tb_core_out_uart_tx: directed bench for core_out_uart_tx with a UART line receiver.
module tb_core_out_uart_tx;
    localparam int CPB = 4;
    localparam int L2  = 2;

    logic          clock, reset_n, out_en, overflow_clear, tx, busy, overflow;
    logic [7:0]    out_data;
    logic [L2:0]   fifo_count;

    core_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(L2)) dut (
        .clock(clock), .reset_n(reset_n), .out_en(out_en), .out_data(out_data),
        .overflow_clear(overflow_clear), .tx(tx), .busy(busy),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       tx;
        logic       busy;
        logic [2:0] cnt;
    } vec_t;

    vec_t       v [43];
    logic       bits41 [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int         frame_err = 0;
    int         errors = 0;
    int         checks = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // line receiver: samples each bit in its second clock of the bit period
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (reset_n && tx === 1'b0) begin
                @(negedge clock);
                if (tx !== 1'b0) frame_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clock);
                if (tx !== 1'b1) frame_err++;
                rx_q.push_back(b);
            end
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(logic [7:0] d);
        out_en = 1'b1;
        out_data = d;
        @(posedge clock);
        #1;
        out_en = 1'b0;
        out_data = 8'h00;
    endtask

    task automatic check_rx(string name);
        int t = 0;
        int n = exp_q.size();
        while (rx_q.size() < n && t < (n * 12 + 20) * CPB) begin
            @(negedge clock);
            t++;
        end
        repeat (3 * CPB) @(negedge clock);
        check({name, " frame count"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            check($sformatf("%s byte %0d", name, i), rx_q[i], exp_q[i]);
        check({name, " framing"}, frame_err, 0);
        check({name, " busy after drain"}, busy, 0);
        rx_q.delete();
        exp_q.delete();
        frame_err = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        out_en = 1'b0;
        out_data = 8'h00;
        overflow_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset count", fifo_count, 0);
        check("reset overflow", overflow, 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // single byte 0x41, cycle-exact waveform
        v[0] = '{1'b1, 8'h41, 1'b1, 1'b1, 3'd1};
        for (int c = 1; c <= 4; c++) v[c] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0};
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < CPB; k++) v[5 + 4 * i + k] = '{1'b0, 8'h00, bits41[i], 1'b1, 3'd0};
        for (int c = 37; c <= 40; c++) v[c] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0};
        for (int c = 41; c <= 42; c++) v[c] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0};
        for (int c = 0; c < 43; c++) begin
            out_en = v[c].en;
            out_data = v[c].d;
            @(posedge clock);
            #1;
            out_en = 1'b0;
            @(negedge clock);
            check($sformatf("t1 tx c%0d", c), tx, v[c].tx);
            check($sformatf("t1 busy c%0d", c), busy, v[c].busy);
            check($sformatf("t1 count c%0d", c), fifo_count, v[c].cnt);
        end
        exp_q = '{8'h41};
        check_rx("t1");

        // burst of 5 while idle
        begin
            logic [2:0] cnts [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
            for (int i = 0; i < 5; i++) begin
                strobe(8'(i + 1));
                check($sformatf("t2 count %0d", i), fifo_count, cnts[i]);
            end
        end
        check("t2 overflow", overflow, 0);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("t2");

        // overflow: sixth byte dropped
        for (int i = 0; i < 6; i++) strobe(8'h10 + 8'(i));
        check("t3 overflow set", overflow, 1);
        check("t3 count", fifo_count, 4);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        check_rx("t3");
        check("t3 overflow sticky", overflow, 1);
        overflow_clear = 1'b1;
        @(posedge clock);
        #1;
        overflow_clear = 1'b0;
        check("t3 overflow cleared", overflow, 0);

        // full FIFO with a write on the pop edge, then set-vs-clear priority
        for (int i = 0; i < 5; i++) strobe(8'hA0 + 8'(i));
        repeat (37) @(posedge clock);
        #1;
        check("t4 idle gap tx", tx, 1);
        check("t4 full before pop", fifo_count, 4);
        strobe(8'h77);
        check("t4 count stays", fifo_count, 4);
        check("t4 no overflow", overflow, 0);
        check("t4 popped tx", tx, 0);
        overflow_clear = 1'b1;
        strobe(8'h99);
        overflow_clear = 1'b0;
        check("t4 set beats clear", overflow, 1);
        check("t4 count full", fifo_count, 4);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h77};
        check_rx("t4");
        overflow_clear = 1'b1;
        @(posedge clock);
        #1;
        overflow_clear = 1'b0;

        // reset during data bit 3 of 0xC3 with bytes queued
        strobe(8'hC3);
        strobe(8'h11);
        strobe(8'h22);
        repeat (16) @(posedge clock);
        #1;
        check("t5 bit3 before reset", tx, 0);
        check("t5 queued before reset", fifo_count, 2);
        reset_n = 1'b0;
        #1;
        check("t5 async tx", tx, 1);
        check("t5 async count", fifo_count, 0);
        check("t5 async busy", busy, 0);
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        repeat (12 * CPB) @(posedge clock);
        #1;
        check("t5 quiet after reset", tx, 1);
        rx_q.delete();
        frame_err = 0;
        strobe(8'h5A);
        exp_q = '{8'h5A};
        check_rx("t5");

        // three groups of four bytes, pointers wrap
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) begin
                strobe(8'h30 + 8'(g * 4 + i));
                exp_q.push_back(8'h30 + 8'(g * 4 + i));
            end
            check($sformatf("t6 count g%0d", g), fifo_count, 3);
            check_rx($sformatf("t6 g%0d", g));
        end
        check("t6 overflow", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
